// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: shares one fixed-latency single-ported memory between the
// fetch (I) and data (D) pipeline stages, data first.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rdy,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_re,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int               CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               owner_d;
  logic               op_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic               d_req;
  logic               grant_d;
  logic               grant_i;
  logic               done;
  logic               busy;

  assign d_req = d_re | d_we;
  assign busy  = (state == BUSY);

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // MEM holds the older instruction, so it always wins.
        if (d_req) begin
          grant_d   = 1'b1;
          state_nxt = BUSY;
        end else if (i_req) begin
          grant_i   = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          done      = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      owner_d   <= 1'b0;
      op_we     <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      if (grant_d) begin
        owner_d   <= 1'b1;
        op_we     <= d_we;
        lat_addr  <= d_addr;
        lat_wdata <= d_wdata;
        cnt       <= CNT_LOAD;
      end else if (grant_i) begin
        owner_d   <= 1'b0;
        op_we     <= 1'b0;
        lat_addr  <= i_addr;
        lat_wdata <= '0;
        cnt       <= CNT_LOAD;
      end else if (busy && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      // Writes leave the load-data register untouched.
      if (done && !op_we) begin
        if (owner_d) begin
          d_rdata <= m_rdata;
        end else begin
          i_rdata <= m_rdata;
        end
      end
    end
  end

  assign m_re      = busy & ~op_we;
  assign m_we      = busy & op_we;
  assign m_addr    = busy ? lat_addr  : '0;
  assign m_wdata   = busy ? lat_wdata : '0;

  assign i_rdy     = (state == RESP) & ~owner_d;
  assign d_rdy     = (state == RESP) & owner_d;

  assign stall_if  = i_req & ~i_rdy;
  assign stall_mem = d_req & ~d_rdy;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported, fixed-latency unified memory between the IF stage (instruction fetch) and the MEM stage (data load/store) of the 5-stage pipeline. Grants one access at a time and sequences it over the memory's access latency. Returns data and a one-cycle ready pulse to the winning requester, and drives stall signals into the hazard logic so the pipeline freezes while an access is outstanding.

Parameters:
MEM_LAT, 4, backing-memory access latency in cycles (legal range 1..15)
ADDR_W, 16, address width
DATA_W, 16, data width

Ports:
clk  in  1  system clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; level, held until i_rdy
i_addr  in  ADDR_W  fetch address
i_rdy  out  1  one-cycle pulse: fetch complete, i_rdata valid
i_rdata  out  DATA_W  fetched instruction, registered
d_re  in  1  data read request; level, held until d_rdy
d_we  in  1  data write request; level, held until d_rdy
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdy  out  1  one-cycle pulse: data access complete
d_rdata  out  DATA_W  load data, registered
m_re  out  1  memory read enable
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data, valid in last BUSY cycle
stall_if  out  1  combinational: i_req & ~i_rdy
stall_mem  out  1  combinational: (d_re|d_we) & ~d_rdy

Behaviour:
- Reset (async, any state, mid-access included):
  - state=IDLE, counter=0, owner=I.
  - i_rdy, d_rdy, m_re, m_we = 0; m_addr, m_wdata, i_rdata, d_rdata = 0.
  - An in-flight access is abandoned; no rdy pulse is produced.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If d_re|d_we: grant D. Data has strict priority because the MEM stage holds the older instruction.
  - Else if i_req: grant I.
  - Else stay in IDLE.
  - On grant: latch owner, address, wdata and op type (write if d_we, else read) into registers; load counter=MEM_LAT-1; go to BUSY.
- d_re and d_we both high: treated as a write; d_re is ignored.
- BUSY:
  - m_addr, m_wdata, m_re, m_we are driven from the latched registers, held stable for exactly MEM_LAT cycles.
  - Counter decrements each cycle.
  - At counter==0: capture m_rdata into the owner's rdata register (reads only; writes leave d_rdata unchanged); go to RESP.
- RESP:
  - One cycle; the owner's rdy=1 and the other rdy=0.
  - m_re=m_we=0, m_addr=0.
  - Next state is IDLE.
- Latency: request visible in IDLE at cycle t -> BUSY cycles t+1..t+MEM_LAT -> rdy in cycle t+MEM_LAT+1 -> IDLE at t+MEM_LAT+2.
  - Occupancy is MEM_LAT+2 cycles per access.
  - The RESP cycle guarantees the requester updates its request before the next arbitration, so a stale request is never re-granted.
- Outside BUSY: m_re=m_we=0 and m_addr=m_wdata=0.
- Request deasserted mid-BUSY: the access still completes and rdy still pulses. Requesters must not do this; no assertion is required.
- Request/address changes during BUSY have no effect (latched copy is used).
- rdata registers hold their value until the next completed read for that port.
- i_rdy and d_rdy are never high in the same cycle.
- A pending fetch waits for all back-to-back data accesses. Starvation is bounded by pipeline structure, not by the arbiter.

Test Plan:
1. MEM_LAT=4, reset, then i_req=1, i_addr=0x0010, memory returns 0xB123 -> m_re high cycles 1-4 with m_addr=0x0010; i_rdy pulse in cycle 5; i_rdata=0xB123; stall_if high cycles 0-4, low in 5.
2. i_req and d_re asserted same cycle (d_addr=0x0200, i_addr=0x0011) -> data granted first (d_rdy in cycle 5); fetch granted in next IDLE (cycle 6), i_rdy in cycle 11; stall_if high throughout cycles 0-10.
3. d_we=1, d_addr=0x0030, d_wdata=0xCAFE -> m_we=1, m_wdata=0xCAFE for 4 cycles; d_rdy pulse; d_rdata unchanged from prior value 0x1234.
4. d_re=d_we=1 -> performs write only (m_re stays 0); d_rdy pulses once.
5. rst_n pulled low in 2nd BUSY cycle of a fetch -> outputs zero immediately (async); after release no i_rdy pulse until a fresh request; a new request completes normally.
6. MEM_LAT=1, back-to-back fetches 0x0000, 0x0001 -> each access occupies 3 cycles; i_rdy pulses in cycles 2 and 5 with correct data.
